sseg_scan4: RTL and testbench



---
 rtl/sseg_pkg.sv | 27 ++
 rtl/sseg_decoder.sv | 34 +++
 rtl/sseg_scan4.sv | 113 +++++++++++
 tb/tb_sseg_scan4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b1000000;
  localparam seg_t SEG_1   = 7'b1111001;
  localparam seg_t SEG_2   = 7'b0100100;
  localparam seg_t SEG_3   = 7'b0110000;
  localparam seg_t SEG_4   = 7'b0011001;
  localparam seg_t SEG_5   = 7'b0010010;
  localparam seg_t SEG_6   = 7'b0000010;
  localparam seg_t SEG_7   = 7'b1111000;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0010000;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b0000011;
  localparam seg_t SEG_C   = 7'b1000110;
  localparam seg_t SEG_D   = 7'b0100001;
  localparam seg_t SEG_E   = 7'b0000110;
  localparam seg_t SEG_F   = 7'b0001110;
  localparam seg_t SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational 4-bit code to active-low segment pattern.
// Codes above 9 render as hex glyphs for debug.
module sseg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] code_i,
  output seg_t       seg_o
);

  // Glyph lookup
  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sseg_scan4.sv
// Four-digit common-anode display scanner: slot timer, leading-zero blanking,
// anti-ghosting guard and registered pin drivers.
module sseg_scan4
  import sseg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    nib_s;
  seg_t          dec_s;
  logic [3:0]    zero_s;
  logic          lz_s;
  logic          guard_s;
  logic          vis_s;

  // Slot timer and digit index
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
  end

  // Per-digit zero flags feed blanking; disabled digits still count by value
  always_comb begin
    zero_s = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      zero_s[j] = (digits[4*j +: 4] == 4'h0);
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero
  always_comb begin
    lz_s = 1'b0;
    case (idx_q)
      2'd1:    lz_s = blank_lz & zero_s[3] & zero_s[2] & zero_s[1];
      2'd2:    lz_s = blank_lz & zero_s[3] & zero_s[2];
      2'd3:    lz_s = blank_lz & zero_s[3];
      default: lz_s = 1'b0;
    endcase
  end

  assign nib_s   = digits[{idx_q, 2'b00} +: 4];
  assign guard_s = (cnt_q < CW'(GUARD));
  assign vis_s   = en[idx_q] & ~lz_s & ~guard_s;

  sseg_decoder u_dec (
    .code_i (nib_s),
    .seg_o  (dec_s)
  );

  // Next pin state: at most one anode low, never inside the guard
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (vis_s) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_s;
      dp_d  = ~dp_in[idx_q];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // State and output registers; reset aborts the slot in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sseg_scan4.sv
// Scoreboard bench for sseg_scan4: a frame-position reference model pushes the
// expected pin state each edge; a negedge monitor pops and compares.
module tb_sseg_scan4;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;
  localparam logic [11:0] OFF = {4'b1111, 7'b1111111, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  en = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  sseg_scan4 #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk      (clk),
    .rst      (rst),
    .digits   (digits),
    .dp_in    (dp_in),
    .en       (en),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  int          m_pos = 0;
  bit          m_live = 1'b0;

  logic [6:0] ref_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Expected {an,seg,dp} for frame position pos under the given inputs
  function automatic logic [11:0] model(int pos, logic [15:0] d, logic [3:0] e,
                                        logic [3:0] p, logic b);
    int slot;
    int c;
    int upper;
    int nib;
    bit lz;
    slot  = pos / DIV;
    c     = pos % DIV;
    upper = int'(d) >> (4 * slot);
    nib   = upper & 15;
    lz    = b && (slot > 0) && (upper == 0);
    if (c < GUARD) return OFF;
    if (!e[slot] || lz) return OFF;
    return {4'(15 - (1 << slot)), ref_seg[nib], ~p[slot]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back(OFF);
      m_pos  <= 0;
      m_live <= 1'b1;
    end else if (m_live) begin
      exp_q.push_back(model(m_pos, digits, en, dp_in, blank_lz));
      m_pos <= (m_pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({an, seg, dp} !== e) begin
        n_err++;
        $display("FAIL pins t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 $time, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t: got an=%b, want at most one low", $time, an);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(int slot, int c);
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (m_pos == slot * DIV + c) return;
      step(1);
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_pos: got pos=%0d, want %0d within budget", m_pos, slot * DIV + c);
  endtask

  initial begin
    rst      = 1'b1;
    digits   = 16'h1234;
    en       = 4'hF;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    step(2);
    rst = 1'b0;
    step(2 * FRAME);

    digits   = 16'h0042;
    blank_lz = 1'b1;
    step(FRAME);
    digits = 16'h0000;
    step(FRAME);
    digits = 16'h0100;
    step(FRAME);

    en       = 4'b0101;
    dp_in    = 4'b0100;
    blank_lz = 1'b0;
    digits   = 16'h8888;
    step(FRAME);

    en    = 4'hF;
    dp_in = 4'h0;
    wait_pos(2, 5);
    rst = 1'b1;
    step(1);
    n_cmp++;
    if (dut.idx_q !== 2'd0 || dut.cnt_q !== '0) begin
      n_err++;
      $display("FAIL rst_state: got idx=%0d cnt=%0d, want idx=0 cnt=0", dut.idx_q, dut.cnt_q);
    end
    rst = 1'b0;
    step(FRAME);

    digits = 16'h1239;
    wait_pos(0, 4);
    digits = 16'h123A;
    step(FRAME);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int j = 0; j < 4; j++) begin
          digits[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        en       = 4'($urandom_range(0, 15));
        dp_in    = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 149) == 0);
      step(1);
    end

    rst = 1'b0;
    step(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
